ifd_fetch_decode: RTL

- PDP-8 instruction fetch/decode stage. Sits between main memory and the EXEC unit.
- Fetches the 12-bit word at the PC supplied by EXEC and decodes it into memory-reference or group-1/2 operate (op7) controls.
- Paces itself on EXEC's stall handshake.
- Drives base_addr, the first-instruction address, to EXEC.

---
 rtl/ifd_fetch_decode.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ifd_fetch_decode.sv
// PDP-8 instruction fetch/decode stage.
// Reads the word at EXEC's PC from memory and decodes it. Memory-reference
// instructions produce one-hot mem_op controls. Opcode 7 produces operate
// bits. Opcode 6 (IOT) is flagged as illegal. Fetches are paced by EXEC's
// stall handshake.
// Optional feature macro: IFD_IND_RESOLVE_EN. When it is defined, the
// indirect operand pointer is read from memory before instr_valid is raised.
`timescale 1ns/1ps
module ifd_fetch_decode #(
  parameter logic [11:0] START_ADDR = 12'o200,
  parameter int unsigned MEM_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [11:0] PC_value,
  output logic        rd_req,
  output logic [11:0] rd_addr,
  input  logic [11:0] rd_data,
  output logic [11:0] base_addr,
  output logic        instr_valid,
  output logic [5:0]  mem_op,
  output logic [11:0] mem_addr,
  output logic        indirect,
  output logic        op7_valid,
  output logic [8:0]  op7_bits,
  output logic        illegal_instr
);

  typedef enum logic [2:0] {
    S_INIT,
    S_FETCH,
    S_WAIT_MEM,
    S_DECODE,
    S_WAIT_ACK,
    S_IND_FETCH,
    S_IND_WAIT
  } state_t;

  // Wait counter reload: the counter reaches zero in the cycle in which
  // the read data is valid.
  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [11:0] r_pc;
  logic [11:0] r_word;
  logic        r_rd_req;
  logic [11:0] r_rd_addr;
  logic        r_instr_valid;
  logic [5:0]  r_mem_op;
  logic [11:0] r_mem_addr;
  logic        r_indirect;
  logic        r_op7_valid;
  logic [8:0]  r_op7_bits;
  logic        r_illegal;

  logic [2:0]  w_opcode;
  logic        w_is_mem;
  logic [5:0]  w_onehot;
  logic [11:0] w_direct;

  // Decode fields of the captured word. Page-relative addressing takes the
  // page (PC[11:7]) from the latched PC, never from the live PC_value.
  assign w_opcode = r_word[11:9];
  assign w_is_mem = (w_opcode != 3'd6) && (w_opcode != 3'd7);
  assign w_onehot = 6'b000001 << w_opcode;
  assign w_direct = r_word[7] ? {r_pc[11:7], r_word[6:0]} : {5'b0, r_word[6:0]};

  // Fetch/decode sequencer with registered outputs. The pulses default low each cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_INIT;
      r_cnt         <= 3'd0;
      r_pc          <= 12'd0;
      r_word        <= 12'd0;
      r_rd_req      <= 1'b0;
      r_rd_addr     <= 12'd0;
      r_instr_valid <= 1'b0;
      r_mem_op      <= 6'd0;
      r_mem_addr    <= 12'd0;
      r_indirect    <= 1'b0;
      r_op7_valid   <= 1'b0;
      r_op7_bits    <= 9'd0;
      r_illegal     <= 1'b0;
    end else begin
      r_rd_req      <= 1'b0;
      r_instr_valid <= 1'b0;
      r_illegal     <= 1'b0;
      case (r_state)
        S_INIT: r_state <= S_FETCH;
        S_FETCH: begin
          if (!stall) begin
            r_rd_req  <= 1'b1;
            r_rd_addr <= PC_value;
            r_pc      <= PC_value;
            r_state   <= S_WAIT_MEM;
          end
        end
        S_WAIT_MEM: begin
          if (r_rd_req) begin
            r_cnt <= LAT_M1;
          end else if (r_cnt == 3'd0) begin
            r_word  <= rd_data;
            r_state <= S_DECODE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_DECODE: begin
`ifdef IFD_IND_RESOLVE_EN
          if (w_is_mem && r_word[8]) begin
            r_state <= S_IND_FETCH;
          end else
`endif
          begin
            r_instr_valid <= 1'b1;
            r_illegal     <= (w_opcode == 3'd6);
            r_mem_op      <= w_is_mem ? w_onehot : 6'd0;
            r_mem_addr    <= w_is_mem ? w_direct : 12'd0;
            r_indirect    <= w_is_mem & r_word[8];
            r_op7_valid   <= (w_opcode == 3'd7);
            r_op7_bits    <= (w_opcode == 3'd7) ? r_word[8:0] : 9'd0;
            r_state       <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (stall) begin
            r_state <= S_FETCH;
          end
        end
`ifdef IFD_IND_RESOLVE_EN
        S_IND_FETCH: begin
          r_rd_req  <= 1'b1;
          r_rd_addr <= w_direct;
          r_state   <= S_IND_WAIT;
        end
        S_IND_WAIT: begin
          if (r_rd_req) begin
            r_cnt <= LAT_M1;
          end else if (r_cnt == 3'd0) begin
            r_instr_valid <= 1'b1;
            r_mem_op      <= w_onehot;
            r_mem_addr    <= rd_data;
            r_indirect    <= 1'b0;
            r_op7_valid   <= 1'b0;
            r_op7_bits    <= 9'd0;
            r_state       <= S_WAIT_ACK;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
`endif
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign base_addr     = START_ADDR;
  assign rd_req        = r_rd_req;
  assign rd_addr       = r_rd_addr;
  assign instr_valid   = r_instr_valid;
  assign mem_op        = r_mem_op;
  assign mem_addr      = r_mem_addr;
  assign indirect      = r_indirect;
  assign op7_valid     = r_op7_valid;
  assign op7_bits      = r_op7_bits;
  assign illegal_instr = r_illegal;

endmodule
